// File: rtl/id_operand_fetch.sv
// Operand fetch for the decode stage: register-file addressing, EX/MEM forwarding,
// load-use hazard detection and the ID/EX pipeline register.
module id_operand_fetch #(
  parameter int WORD_W = 32,
  parameter int PC_W   = 30,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              dec_en,
  input  logic [PC_W-1:0]   dec_pc,
  input  logic [REG_AW-1:0] dec_ra_addr,
  input  logic [REG_AW-1:0] dec_rb_addr,
  input  logic              dec_ra_use,
  input  logic              dec_rb_use,
  input  logic [REG_AW-1:0] dec_dst_addr,
  input  logic              dec_gpr_we_,
  input  logic              dec_is_load,
  output logic [REG_AW-1:0] gpr_rd_addr_0,
  output logic [REG_AW-1:0] gpr_rd_addr_1,
  input  logic [WORD_W-1:0] gpr_rd_data_0,
  input  logic [WORD_W-1:0] gpr_rd_data_1,
  input  logic              ex_en,
  input  logic              ex_gpr_we_,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] ex_dst_addr,
  input  logic [WORD_W-1:0] ex_fwd_data,
  input  logic              mem_en,
  input  logic              mem_gpr_we_,
  input  logic [REG_AW-1:0] mem_dst_addr,
  input  logic [WORD_W-1:0] mem_fwd_data,
  output logic              ld_hazard,
  output logic              id_en,
  output logic [PC_W-1:0]   id_pc,
  output logic [WORD_W-1:0] id_ra_data,
  output logic [WORD_W-1:0] id_rb_data,
  output logic [REG_AW-1:0] id_dst_addr,
  output logic              id_gpr_we_,
  output logic              id_is_load
);

  logic              ex_hit, mem_hit;
  logic              ex_ra_hit, ex_rb_hit;
  logic [WORD_W-1:0] ra_fwd, rb_fwd;

  logic              en_q, en_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [WORD_W-1:0] ra_q, ra_d;
  logic [WORD_W-1:0] rb_q, rb_d;
  logic [REG_AW-1:0] dst_q, dst_d;
  logic              we_n_q, we_n_d;
  logic              ld_q, ld_d;

  assign gpr_rd_addr_0 = dec_ra_addr;
  assign gpr_rd_addr_1 = dec_rb_addr;

  assign ex_hit    = ex_en & ~ex_gpr_we_;
  assign mem_hit   = mem_en & ~mem_gpr_we_;
  assign ex_ra_hit = ex_hit & (ex_dst_addr == dec_ra_addr);
  assign ex_rb_hit = ex_hit & (ex_dst_addr == dec_rb_addr);

  // A load in EX has no data yet, so it is skipped here and covered by the hazard bubble.
  always_comb begin
    ra_fwd = gpr_rd_data_0;
    if (ex_ra_hit && !ex_is_load)
      ra_fwd = ex_fwd_data;
    else if (mem_hit && (mem_dst_addr == dec_ra_addr))
      ra_fwd = mem_fwd_data;
  end

  always_comb begin
    rb_fwd = gpr_rd_data_1;
    if (ex_rb_hit && !ex_is_load)
      rb_fwd = ex_fwd_data;
    else if (mem_hit && (mem_dst_addr == dec_rb_addr))
      rb_fwd = mem_fwd_data;
  end

  assign ld_hazard = dec_en & ex_is_load &
                     ((dec_ra_use & ex_ra_hit) | (dec_rb_use & ex_rb_hit));

  always_comb begin
    en_d   = en_q;
    pc_d   = pc_q;
    ra_d   = ra_q;
    rb_d   = rb_q;
    dst_d  = dst_q;
    we_n_d = we_n_q;
    ld_d   = ld_q;
    if (flush || (!stall && ld_hazard)) begin
      en_d   = 1'b0;
      we_n_d = 1'b1;
      ld_d   = 1'b0;
    end else if (!stall) begin
      en_d   = dec_en;
      pc_d   = dec_pc;
      ra_d   = ra_fwd;
      rb_d   = rb_fwd;
      dst_d  = dec_dst_addr;
      we_n_d = dec_gpr_we_ | ~dec_en;
      ld_d   = dec_is_load;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_q   <= 1'b0;
      pc_q   <= '0;
      ra_q   <= '0;
      rb_q   <= '0;
      dst_q  <= '0;
      we_n_q <= 1'b1;
      ld_q   <= 1'b0;
    end else begin
      en_q   <= en_d;
      pc_q   <= pc_d;
      ra_q   <= ra_d;
      rb_q   <= rb_d;
      dst_q  <= dst_d;
      we_n_q <= we_n_d;
      ld_q   <= ld_d;
    end
  end

  assign id_en       = en_q;
  assign id_pc       = pc_q;
  assign id_ra_data  = ra_q;
  assign id_rb_data  = rb_q;
  assign id_dst_addr = dst_q;
  assign id_gpr_we_  = we_n_q;
  assign id_is_load  = ld_q;

endmodule
